// File: rtl/ffs_arbiter.sv
// rtl/ffs_arbiter.sv - round-robin front end sharing one findfirstset pipeline
//
// Arbitrates NREQ requesters onto a single findfirstset (FFS) pipeline, tags
// each issued vector with its owner, and routes results back as one-cycle
// responses.
//
// Ports:
//   clk, reset      clock; asynchronous active-low reset
//   issue_en        permits new grants (0 lets in-flight work drain)
//   req_valid/data  per-requester request and W-bit search vector
//   req_ready       one-hot (or zero) combinational grant
//   ffs_in_valid/in registered vector toward the FFS pipeline
//   ffs_result      FFS result, qualified by ffs_out_valid
//   rsp_valid       one-hot response pulse to the owning requester
//   rsp_result      lowest set bit index (0 for an all-zero vector)
//   rsp_zero        original vector was all zeros
//   inflight        issued but not yet responded count
//   err             sticky protocol mismatch between tags and FFS output
module ffs_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 1024,
    parameter int RW   = 10,
    parameter int LAT  = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_en,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*W-1:0]        req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     ffs_in_valid,
    output logic [W-1:0]             ffs_in,
    input  logic [RW-1:0]            ffs_result,
    input  logic                     ffs_out_valid,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [RW-1:0]            rsp_result,
    output logic                     rsp_zero,
    output logic [$clog2(LAT+2)-1:0] inflight,
    output logic                     err
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(LAT + 2);
    // Stage 0 is loaded alongside ffs_in; the remaining LAT stages track the
    // FFS pipeline, so the last stage lines up with ffs_out_valid.
    localparam int TD = LAT + 1;

    logic [IW-1:0]         rr_ptr;
    logic [IW-1:0]         gnt_id;
    logic                  found;
    logic                  xfer;
    logic [IW:0]           cand;
    logic [W-1:0]          gnt_vec;

    logic [TD-1:0]         tag_v;
    logic [TD-1:0][IW-1:0] tag_id;
    logic [TD-1:0]         tag_z;
    logic                  tag_out_v;
    logic [IW-1:0]         tag_out_id;
    logic                  tag_out_z;

    // Rotating priority search starting at rr_ptr.
    always_comb begin
        found     = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!found && req_valid[cand[IW-1:0]]) begin
                found  = 1'b1;
                gnt_id = cand[IW-1:0];
            end
        end
        if (issue_en && found) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign xfer       = issue_en && found;
    assign gnt_vec    = req_data[int'(gnt_id)*W +: W];
    assign tag_out_v  = tag_v[TD-1];
    assign tag_out_id = tag_id[TD-1];
    assign tag_out_z  = tag_z[TD-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr       <= '0;
            ffs_in_valid <= 1'b0;
            ffs_in       <= '0;
            tag_v        <= '0;
            tag_id       <= '0;
            tag_z        <= '0;
        end else begin
            ffs_in_valid <= xfer;
            if (xfer) begin
                ffs_in <= gnt_vec;
                rr_ptr <= (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + IW'(1);
            end
            tag_v  <= {tag_v[TD-2:0], xfer};
            tag_id <= {tag_id[TD-2:0], gnt_id};
            tag_z  <= {tag_z[TD-2:0], ~|gnt_vec};
        end
    end

    // A valid tag always produces a response, even if the FFS output is
    // missing (result taken as is); an untagged FFS output is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            inflight   <= '0;
            err        <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (tag_out_v) begin
                rsp_valid[tag_out_id] <= 1'b1;
                rsp_result            <= tag_out_z ? '0 : ffs_result;
                rsp_zero              <= tag_out_z;
            end
            if (ffs_out_valid != tag_out_v) begin
                err <= 1'b1;
            end
            case ({xfer, tag_out_v})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end
endmodule

// File: tb/tb_ffs_arbiter.sv
// tb/tb_ffs_arbiter.sv - self-checking bench for ffs_arbiter with FFS pipeline model
module tb_ffs_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 1024;
    localparam int RW   = 10;
    localparam int LAT  = 10;
    localparam int CW   = $clog2(LAT + 2);

    logic              clk = 1'b0;
    logic              reset;
    logic              issue_en;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              ffs_in_valid;
    logic [W-1:0]      ffs_in;
    logic [RW-1:0]     ffs_result;
    logic              ffs_out_valid;
    logic [NREQ-1:0]   rsp_valid;
    logic [RW-1:0]     rsp_result;
    logic              rsp_zero;
    logic [CW-1:0]     inflight;
    logic              err;

    always #5 clk = ~clk;

    ffs_arbiter #(.NREQ(NREQ), .W(W), .RW(RW), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .issue_en(issue_en),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .ffs_in_valid(ffs_in_valid), .ffs_in(ffs_in),
        .ffs_result(ffs_result), .ffs_out_valid(ffs_out_valid),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .inflight(inflight), .err(err)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model state: expected responses indexed by due cycle,
    // FFS pipeline outputs indexed by the cycle they are presented.
    int            m_rr;
    int            m_inflight;
    logic [RW-1:0] m_res;
    logic          m_zero;
    logic          m_err;
    logic          m_err_next;
    logic [W-1:0]  m_in;
    logic          m_in_v;
    bit            e_v   [64];
    int            e_id  [64];
    logic [RW-1:0] e_res [64];
    bit            e_z   [64];
    bit            p_v   [64];
    logic [RW-1:0] p_res [64];
    logic [NREQ-1:0] last_rdy;
    int            obs_peak;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [RW-1:0] first_set(input logic [W-1:0] v);
        for (int i = 0; i < W; i++) begin
            if (v[i]) return RW'(i);
        end
        return '0;
    endfunction

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        int mode;
        v = '0;
        mode = $urandom_range(3, 0);
        if (mode == 1) begin
            v[$urandom_range(W-1, 0)] = 1'b1;
        end else if (mode == 2) begin
            for (int n = 0; n < 4; n++) v[$urandom_range(W-1, 0)] = 1'b1;
        end else if (mode == 3) begin
            for (int w = 0; w < W/32; w++) v[w*32 +: 32] = $urandom;
        end
        return v;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 64; i++) begin
            e_v[i] = 1'b0;
            p_v[i] = 1'b0;
        end
        m_rr = 0; m_inflight = 0; m_res = '0; m_zero = 1'b0;
        m_err = 1'b0; m_err_next = 1'b0; m_in = '0; m_in_v = 1'b0;
    endtask

    // One clock: check the grant for the current inputs, cross the edge,
    // check registered outputs, then advance the FFS pipeline model.
    task automatic cycle();
        int g;
        int due;
        logic [W-1:0] v;
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] exp_rsp;
        #1;
        g = -1;
        if (issue_en) begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_rr + k) % NREQ;
                if (req_valid[j] && g < 0) g = j;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        last_rdy = req_ready;
        chk("req_ready", W'(req_ready), W'(exp_rdy));
        m_in_v = 1'b0;
        if (g >= 0) begin
            v = req_data[g*W +: W];
            due = (cyc + 1 + LAT + 1) % 64;
            e_v[due] = 1'b1; e_id[due] = g; e_z[due] = (v == '0); e_res[due] = first_set(v);
            m_rr = (g + 1) % NREQ;
            m_inflight++;
            m_in_v = 1'b1;
            m_in = v;
        end

        @(posedge clk);
        cyc++;
        #1;
        exp_rsp = '0;
        if (e_v[cyc%64]) begin
            exp_rsp[e_id[cyc%64]] = 1'b1;
            m_res  = e_res[cyc%64];
            m_zero = e_z[cyc%64];
            m_inflight--;
            e_v[cyc%64] = 1'b0;
        end
        if (m_err_next) m_err = 1'b1;
        chk("rsp_valid", W'(rsp_valid), W'(exp_rsp));
        chk("rsp_result", W'(rsp_result), W'(m_res));
        chk("rsp_zero", W'(rsp_zero), W'(m_zero));
        chk("inflight", W'(inflight), W'(m_inflight));
        chk("ffs_in_valid", W'(ffs_in_valid), W'(m_in_v));
        chk("ffs_in", ffs_in, m_in);
        chk("err", W'(err), W'(m_err));
        if (int'(inflight) > obs_peak) obs_peak = int'(inflight);

        ffs_out_valid = p_v[cyc%64];
        ffs_result    = p_res[cyc%64];
        p_v[cyc%64]   = 1'b0;
        m_err_next    = (ffs_out_valid != e_v[(cyc+1)%64]);
        if (ffs_in_valid) begin
            p_v[(cyc+LAT)%64]   = 1'b1;
            p_res[(cyc+LAT)%64] = (ffs_in == '0) ? RW'($urandom) : first_set(ffs_in);
        end
    endtask

    task automatic do_reset(input int hold);
        reset = 1'b0;
        req_valid = '0;
        ffs_out_valid = 1'b0;
        #1;
        chk("rst_ffs_in_valid", W'(ffs_in_valid), '0);
        chk("rst_ffs_in", ffs_in, '0);
        chk("rst_rsp_valid", W'(rsp_valid), '0);
        chk("rst_rsp_result", W'(rsp_result), '0);
        chk("rst_rsp_zero", W'(rsp_zero), '0);
        chk("rst_inflight", W'(inflight), '0);
        chk("rst_err", W'(err), '0);
        clear_model();
        repeat (hold) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1; issue_en = 1'b0; req_valid = '0; req_data = '0;
        ffs_out_valid = 1'b0; ffs_result = '0; obs_peak = 0; last_rdy = '0;
        clear_model();
        #2;
        do_reset(3);

        // Single request from requester 0, bits [7:4] set.
        issue_en = 1'b1;
        req_valid = 4'b0001;
        req_data = '0;
        req_data[7:4] = 4'hF;
        cycle();
        req_valid = '0;
        repeat (LAT + 4) cycle();

        // Requester 2 with an all-zero vector.
        req_data = '0;
        req_valid = 4'b0100;
        cycle();
        req_valid = '0;
        repeat (LAT + 4) cycle();

        // All four requesters at full throughput from rr_ptr = 0.
        do_reset(2);
        req_data = '0;
        req_data[0*W + 0]    = 1'b1;
        req_data[1*W + 100]  = 1'b1;
        req_data[2*W + 500]  = 1'b1;
        req_data[3*W + 1023] = 1'b1;
        req_valid = '1;
        obs_peak = 0;
        for (int k = 0; k < 16; k++) begin
            cycle();
            chk("grant_order", W'(last_rdy), W'(1 << (k % NREQ)));
        end
        req_valid = '0;
        repeat (LAT + 3) cycle();
        chk("inflight_peak", W'(obs_peak), W'(LAT + 1));

        // issue_en low with requests pending: drain, then resume.
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = rand_vec();
        repeat (3) cycle();
        issue_en = 1'b0;
        repeat (LAT + 4) cycle();
        chk("drained", W'(inflight), '0);
        issue_en = 1'b1;
        cycle();
        req_valid = '0;
        repeat (LAT + 3) cycle();

        // Randomized traffic.
        repeat (400) begin
            issue_en  = ($urandom_range(9, 0) != 0);
            req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = rand_vec();
            cycle();
        end
        req_valid = '0;
        repeat (LAT + 4) cycle();

        // Reset in the middle of three in-flight requests.
        issue_en = 1'b1;
        req_valid = '1;
        repeat (3) cycle();
        req_valid = '0;
        repeat (LAT / 2) cycle();
        do_reset(2);
        repeat (LAT + 5) cycle();

        // Spurious FFS output with nothing in flight.
        p_v[(cyc+2)%64]   = 1'b1;
        p_res[(cyc+2)%64] = RW'(77);
        repeat (6) cycle();
        chk("err_spurious", W'(err), W'(1));
        req_data[1*W +: W] = '0;
        req_data[1*W + 33] = 1'b1;
        req_valid = 4'b0010;
        cycle();
        req_valid = '0;
        repeat (LAT + 4) cycle();
        chk("err_sticky", W'(err), W'(1));
        do_reset(2);
        repeat (3) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
